pt_tx_sched: RTL
================

# pt_tx_sched

Transmit scheduler for the PT2262 encoder (`pt_enc`). It accepts 24-bit codewords from a producer such as the 8-to-24 packer through a valid/ready handshake, and buffers them in a small FIFO. It then sequences the encoder: it releases the encoder from reset, counts completed frames until each codeword has gone out `REPEATS` times, and re-arms the encoder for the next codeword. A timeout watchdog aborts a burst if the encoder stalls. It runs entirely in the encoder's 10 kHz clock domain.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `REPEATS`, 7: frames sent per codeword, 1..255.
- `TIMEOUT`, 2048: max `clk` cycles allowed between frame completions before abort, ≥16.
- `GAP_CYCLES`, 64: idle cycles between bursts, used only with `PT_SCHED_GAP_EN`, ≥1.

- `clk`, in, 1: encoder clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `in_data`, in, 24: codeword from producer.
- `in_valid`, in, 1: `in_data` valid.
- `in_ready`, out, 1: FIFO not full.
- `enc_done`, in, 1: encoder level, high when a frame has completed.
- `enc_rst`, out, 1: active-high hold for encoder; low means transmit.
- `enc_ad`, out, 24: codeword presented to encoder.
- `busy`, out, 1: burst in progress (states LOAD/SEND/GAP).
- `level`, out, $clog2(DEPTH)+1: FIFO occupancy.
- `err`, out, 1: sticky timeout flag.
- `err_clr`, in, 1: clears `err`.

## Operation
- FIFO: a push occurs when `in_valid && in_ready`. `in_ready = (level != DEPTH)`. Pointers wrap modulo DEPTH. A push and a pop in the same cycle leave `level` unchanged. A push while full is impossible, because ready is low.
- FSM states: IDLE, LOAD, SEND, GAP.
  - IDLE: `enc_rst=1`. If `level != 0`, pop the head into `enc_ad`, clear the frame counter and timer, and go to LOAD. Otherwise stay in IDLE.
  - LOAD: `enc_rst=1` for exactly one cycle so that `enc_ad` is stable before release. Then go to SEND.
  - SEND: `enc_rst=0`.
    - A rising edge of `enc_done` (registered previous sample 0, current 1) increments the frame counter and clears the timer.
    - When the counter reaches REPEATS, set `enc_rst=1` on the next cycle and go to GAP (macro on) or IDLE (macro off).
    - Timer increments every cycle. When timer == TIMEOUT−1 without an edge, set `err`, set `enc_rst=1`, drop the codeword, and go to IDLE (no gap).
  - GAP: `enc_rst=1`. Count GAP_CYCLES, then go to IDLE.
- `enc_done` level is ignored outside SEND. A `done` already high on entry to SEND is not counted, because the edge detector is preloaded with the current sample in LOAD.
- `err`: set in SEND on timeout, cleared by `err_clr`. If set and clear occur in the same cycle, set wins.
- Frame counter is 8 bits. Timer is $clog2(TIMEOUT) bits. Neither saturates past its terminal compare.

## Timing
- Reset values: `enc_rst=1`, `enc_ad=0`, `busy=0`, `err=0`, `level=0`, `in_ready=1`, FSM in IDLE, pointers 0.
- Reset asserted mid-burst: the encoder is held immediately via the async path (`enc_rst=1`), and FIFO contents are discarded.
- Push to `level` update: 1 cycle.
- Push into an empty FIFO while IDLE: pop at the next edge, LOAD on the following cycle, `enc_rst` low 2 cycles after the push edge.
- The last frame's `done` edge causes `enc_rst` to rise 1 cycle later.
- All outputs are registered except `in_ready`, which is a combinational decode of the registered `level`.

## Configuration
- `PT_SCHED_GAP_EN` defined: a GAP state of GAP_CYCLES cycles with `enc_rst=1` and `busy=1` sits between successive bursts.
- `PT_SCHED_GAP_EN` undefined: SEND goes directly to IDLE, `busy` drops 1 cycle after the final edge, and GAP logic and the `GAP_CYCLES` counter are not synthesized. The parameter is accepted but unused.

## Test plan
- Reset check: assert `rst` low for 3 cycles, then release. `enc_rst=1`, `busy=0`, `in_ready=1`, and `level=0` throughout.
- Single codeword: push 24'hA5C3F0 with an encoder model that raises `done` every 100 cycles. `enc_ad=24'hA5C3F0`, exactly 7 rising `done` edges with `enc_rst=0`, then `enc_rst=1` one cycle after the 7th edge.
- Back-pressure: push 5 words with DEPTH=4 while a burst is active. `in_ready` goes low at `level=4`, the 5th word is accepted after the first pop, and the words are transmitted in push order.
- Gap: with `PT_SCHED_GAP_EN` and GAP_CYCLES=64, push two words. `enc_rst` is high for exactly 64+2 cycles (GAP + IDLE + LOAD) between bursts. Without the macro, the high interval is 2 cycles.
- Timeout: the encoder model never raises `done`, with TIMEOUT=2048. `err=1` and `enc_rst=1` at cycle 2048 of SEND, and the next FIFO word starts. `err_clr` then clears `err`.
- Mid-burst reset: assert `rst` during frame 3 with 2 words queued. `enc_rst=1` asynchronously, `level=0`, and no transmission after release until a new push.

Source files
------------

// File: rtl/pt_tx_sched_if.sv
// Producer-to-scheduler codeword handshake for pt_tx_sched.
interface pt_tx_sched_if;
   logic [23:0] in_data;
   logic        in_valid;
   logic        in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pt_tx_sched.sv
// PT2262 transmit scheduler: buffers codewords and sends each one REPEATS times.
// Define PT_SCHED_GAP_EN to insert a GAP_CYCLES hold between bursts.
module pt_tx_sched #(
   parameter int DEPTH      = 4,
   parameter int REPEATS    = 7,
   parameter int TIMEOUT    = 2048,
   parameter int GAP_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   pt_tx_sched_if.slave           src,
   input  logic                   enc_done,
   output logic                   enc_rst,
   output logic [23:0]            enc_ad,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level,
   output logic                   err,
   input  logic                   err_clr
);
   localparam int         PTR_W    = $clog2(DEPTH);
   localparam int         LVL_W    = PTR_W + 1;
   localparam int         TMR_W    = $clog2(TIMEOUT);
   localparam logic [7:0] REP_LAST = 8'(REPEATS);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REPEATS < 1 || REPEATS > 255 ||
       TIMEOUT < 16 || GAP_CYCLES < 1) begin : g_bad_params
      $error("pt_tx_sched: parameter out of range");
   end

   // state | meaning
   // IDLE  | encoder held, waiting for a queued codeword
   // LOAD  | codeword on enc_ad, encoder held one more cycle to settle
   // SEND  | encoder released, counting done edges and watching the timer
   // GAP   | encoder held between bursts (gap build only)
   typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

   state_t           state;
   logic [23:0]      mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [7:0]       frames;
   logic [TMR_W-1:0] timer;
   logic             done_q;
   logic             push;
   logic             pop;
   logic             done_rise;

   assign src.in_ready = (level != LVL_W'(DEPTH));
   assign push         = src.in_valid && src.in_ready;
   assign pop          = (state == IDLE) && (level != '0);
   assign done_rise    = enc_done && !done_q;

   // Storage carries no reset; only pointers and level define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= src.in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
      end
   end

`ifdef PT_SCHED_GAP_EN
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   logic [GAP_W-1:0] gap_cnt;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         enc_rst <= 1'b1;
         enc_ad  <= '0;
         busy    <= 1'b0;
         err     <= 1'b0;
         frames  <= '0;
         timer   <= '0;
         done_q  <= 1'b0;
`ifdef PT_SCHED_GAP_EN
         gap_cnt <= '0;
`endif
      end else begin
         // A timeout set later in this block overrides the clear.
         if (err_clr) err <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  enc_ad <= mem[rptr];
                  frames <= '0;
                  timer  <= '0;
                  busy   <= 1'b1;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               done_q  <= enc_done;
               enc_rst <= 1'b0;
               state   <= SEND;
            end
            SEND: begin
               done_q <= enc_done;
               if (done_rise) begin
                  frames <= frames + 8'd1;
                  timer  <= '0;
                  if (frames + 8'd1 == REP_LAST) begin
                     enc_rst <= 1'b1;
`ifdef PT_SCHED_GAP_EN
                     gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                     state   <= GAP;
`else
                     busy    <= 1'b0;
                     state   <= IDLE;
`endif
                  end
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  err     <= 1'b1;
                  enc_rst <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
`ifdef PT_SCHED_GAP_EN
            GAP: begin
               if (gap_cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule
